// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial-add controller.
//   DEFAULT_WIDTH    : default number of bits shifted per operation
//   state_t          : FSM state encoding (ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE)
//   ctrl_out_t       : bundle of the Moore control outputs
//   decode_outputs() : maps a state to its control outputs
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic le;
        logic she;
        logic cc;
        logic poute;
        logic busy;
        logic done;
    } ctrl_out_t;

    function automatic ctrl_out_t decode_outputs(input state_t s);
        ctrl_out_t o;
        o = '0;
        case (s)
            ST_LOAD: begin
                o.le   = 1'b1;
                o.cc   = 1'b1;
                o.busy = 1'b1;
            end
            ST_SHIFT: begin
                o.she  = 1'b1;
                o.busy = 1'b1;
            end
            ST_DONE: begin
                o.poute = 1'b1;
                o.done  = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_bit_counter.sv
// Bit counter for the serial-add controller.
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   clear  : force count to 0 (priority over enable)
//   enable : advance the count by one
//   count  : current bit index
//   tc     : terminal count, high when count == WIDTH-1
module bit_counter #(
    parameter int WIDTH = 8,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;
    assign tc    = (count_reg == LAST);

endmodule

// File: rtl/serial_add_ctrl.sv
// Control FSM for a bit-serial adder (accumulator + addend shift registers).
//   CLK   : system clock, RST_N : synchronous active-low reset
//   START : request an operation (IDLE/DONE only), ACK : result taken (DONE only)
//   ABORT : cancel, highest priority after reset
//   LE, SHE, CC, PoutE : load / shift / carry-clear / parallel-out enables
//   BUSY  : LOAD or SHIFT, DONE : result valid until ACK
//   CNT   : bit index of the current shift, 0 outside SHIFT
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             ACK,
    input  logic             ABORT,
    output logic             LE,
    output logic             SHE,
    output logic             CC,
    output logic             PoutE,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] CNT
);

    state_t     state_reg;
    state_t     state_next;
    ctrl_out_t  out_reg;
    logic       cnt_clear;
    logic       cnt_enable;
    logic       cnt_tc;

    always_comb begin
        state_next = state_reg;
        if (ABORT) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (START) state_next = ST_LOAD;
                ST_LOAD:  state_next = ST_SHIFT;
                ST_SHIFT: if (cnt_tc) state_next = ST_DONE;
                ST_DONE:  if (ACK) state_next = START ? ST_LOAD : ST_IDLE;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with
    // state_reg while still being a pure function of it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg <= ST_IDLE;
            out_reg   <= '0;
        end else begin
            state_reg <= state_next;
            out_reg   <= decode_outputs(state_next);
        end
    end

    // The counter only runs while staying in SHIFT; any exit (terminal
    // count or abort) and every non-SHIFT cycle drops it back to 0.
    assign cnt_enable = (state_reg == ST_SHIFT);
    assign cnt_clear  = (state_reg != ST_SHIFT) || (state_next != ST_SHIFT);

    bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (CLK),
        .rst_n  (RST_N),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (CNT),
        .tc     (cnt_tc)
    );

    assign LE    = out_reg.le;
    assign SHE   = out_reg.she;
    assign CC    = out_reg.cc;
    assign PoutE = out_reg.poute;
    assign BUSY  = out_reg.busy;
    assign DONE  = out_reg.done;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed scenarios followed by
// random stimulus, all checked against a cycle-position reference model and
// a bit-serial adder datapath driven by the controller's enables.
module tb_serial_add_ctrl;
    import serial_add_ctrl_pkg::*;

    localparam int W    = DEFAULT_WIDTH;
    localparam int CW   = (W > 1) ? $clog2(W) : 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          ack;
    logic          abort;
    logic          le, she, cc, poute, busy, done;
    logic [CW-1:0] cnt;

    int n_cmp;
    int n_err;

    // Reference model: position within an operation.
    // -1 idle, 0 load cycle, 1..W shift cycles, W+1 result held.
    int op_pos;

    // Datapath built from the controller's enables.
    logic [W-1:0] a_in, b_in;
    logic [W-1:0] acc, addend;
    logic         carry;
    logic [W-1:0] ld_a, ld_b;
    int           she_run;
    logic         prev_done;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .START (start),
        .ACK   (ack),
        .ABORT (abort),
        .LE    (le),
        .SHE   (she),
        .CC    (cc),
        .PoutE (poute),
        .BUSY  (busy),
        .DONE  (done),
        .CNT   (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        logic s;
        if (le) begin
            acc    <= a_in;
            addend <= b_in;
            ld_a   <= a_in;
            ld_b   <= b_in;
        end
        if (cc) carry <= 1'b0;
        if (she) begin
            s      = acc[0] ^ addend[0] ^ carry;
            carry  <= (acc[0] & addend[0]) | (acc[0] & carry) | (addend[0] & carry);
            acc    <= {s, acc[W-1:1]};
            addend <= addend >> 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: the model advances on the same edge using the inputs the
    // DUT sampled, then outputs are compared 1 time unit later.
    task automatic step();
        logic [5:0] exp_ctrl;
        int         exp_cnt;
        logic       e_she;
        @(posedge clk);
        if (!rst_n || abort)            op_pos = -1;
        else if (op_pos == -1)          op_pos = start ? 0 : -1;
        else if (op_pos <= W)           op_pos = op_pos + 1;
        else if (ack)                   op_pos = start ? 0 : -1;
        #1;
        e_she    = (op_pos >= 1) && (op_pos <= W);
        exp_ctrl = {op_pos == 0, e_she, op_pos == 0, op_pos == W + 1,
                    (op_pos >= 0) && (op_pos <= W), op_pos == W + 1};
        exp_cnt  = e_she ? op_pos - 1 : 0;
        check("ctrl{le,she,cc,poute,busy,done}", 32'({le, she, cc, poute, busy, done}), 32'(exp_ctrl));
        check("cnt", 32'(cnt), 32'(exp_cnt));
        if (le) she_run = 0;
        if (she) she_run++;
        if (op_pos == W + 1) begin
            check("pout", 32'(acc), 32'(W'(ld_a + ld_b)));
            if (!prev_done) begin
                check("she_len", 32'(she_run), 32'(W));
                $display("op: a=0x%0h b=0x%0h pout=0x%0h", ld_a, ld_b, acc);
            end
        end
        prev_done = done;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            step();
            k++;
        end
        if (!done) check("wait_done_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_shift_cnt(input int target, input int budget);
        int k;
        k = 0;
        while (!(she && cnt == CW'(target)) && k < budget) begin
            step();
            k++;
        end
        if (!(she && cnt == CW'(target))) check("wait_cnt_timeout", 32'd1, 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        op_pos = -1; she_run = 0; prev_done = 1'b0;
        acc = '0; addend = '0; carry = 1'b0; ld_a = '0; ld_b = '0;
        rst_n = 1'b0; start = 1'b0; ack = 1'b0; abort = 1'b0;
        a_in = 8'b1010_0100; b_in = 8'b0000_0011;

        // Reset for 2 cycles, with START high to show reset wins.
        start = 1'b1;
        run_cycles(2);
        start = 1'b0;
        rst_n = 1'b1;
        step();

        // Basic run with the fixed datapath operands.
        pulse_start();
        wait_done(W + 4);
        check("pout_fixed", 32'(acc), 32'h0000_00A7);
        run_cycles(3);
        ack = 1'b1; step(); ack = 1'b0;
        step();

        // Back-to-back: START and ACK together in DONE.
        a_in = 8'h5C; b_in = 8'h77;
        pulse_start();
        wait_done(W + 4);
        a_in = 8'hFF; b_in = 8'h01;
        start = 1'b1; ack = 1'b1; step();
        start = 1'b0; ack = 1'b0;
        check("b2b_le", 32'(le), 32'd1);
        wait_done(W + 4);
        ack = 1'b1; step(); ack = 1'b0;

        // Abort at CNT=4.
        pulse_start();
        wait_shift_cnt(4, W + 4);
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        run_cycles(W + 3);

        // START held through the whole operation; no restart without ACK.
        a_in = 8'h3E; b_in = 8'hC1;
        start = 1'b1;
        run_cycles(W + 6);
        start = 1'b0;
        ack = 1'b1; step(); ack = 1'b0;
        step();

        // Reset mid-SHIFT at CNT=5, then a full operation.
        pulse_start();
        wait_shift_cnt(5, W + 4);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("rst_all_zero", 32'({le, she, cc, poute, busy, done, cnt}), 32'd0);
        a_in = 8'h81; b_in = 8'h80;
        pulse_start();
        wait_done(W + 4);
        ack = 1'b1; step(); ack = 1'b0;

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 99) < 30);
            ack   = ($urandom_range(0, 99) < 30);
            abort = ($urandom_range(0, 99) < 3);
            rst_n = ($urandom_range(0, 99) >= 1);
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            step();
        end
        start = 1'b0; ack = 1'b0; abort = 1'b0; rst_n = 1'b1;
        run_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 8, number of bits shifted per operation (the accumulator word width).
REQ-002 Port CLK SHALL be: CLK  input  1  single system clock; all state updates on the rising edge.
REQ-003 Port RST_N SHALL be: RST_N  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
REQ-004 Port START SHALL be: START  input  1  request a new serial add; sampled only in IDLE and DONE.
REQ-005 Port ACK SHALL be: ACK  input  1  consumer has taken the parallel result; sampled only in DONE.
REQ-006 Port ABORT SHALL be: ABORT  input  1  cancel the operation in progress.
REQ-007 Port LE SHALL be: LE  output  1  parallel-load enable to the accumulator and addend shift registers.
REQ-008 Port SHE SHALL be: SHE  output  1  shift enable; registers shift one bit (Si in, Sout out) only while high.
REQ-009 Port CC SHALL be: CC  output  1  carry clear to the carry flip-flop.
REQ-010 Port PoutE SHALL be: PoutE  output  1  parallel-output enable to the accumulator.
REQ-011 Port BUSY SHALL be: BUSY  output  1  high in LOAD and SHIFT.
REQ-012 Port DONE SHALL be: DONE  output  1  result valid on Pout; held until accepted.
REQ-013 Port CNT SHALL be: CNT  output  clog2(WIDTH)  bit index of the current shift.

Function
REQ-014 The FSM SHALL have four states, IDLE, LOAD, SHIFT and DONE; all outputs SHALL be Moore-decoded from the state and counter registers.
REQ-015 IDLE SHALL drive all outputs 0; START=1 SHALL transition to LOAD.
REQ-016 LOAD SHALL last exactly 1 cycle with LE=1, CC=1 and BUSY=1; it SHALL clear CNT to 0 and transition to SHIFT.
REQ-017 SHIFT SHALL drive SHE=1 and BUSY=1 for exactly WIDTH consecutive cycles; CNT SHALL increment 0..WIDTH-1, and at CNT=WIDTH-1 the FSM SHALL transition to DONE.
REQ-018 CNT SHALL never wrap within an operation; CNT SHALL hold 0 outside SHIFT.
REQ-019 DONE SHALL drive PoutE=1 and DONE=1, with LE, SHE, CC and BUSY all 0, and SHALL hold until ACK=1.
REQ-020 In DONE, ACK=1 with START=0 SHALL transition to IDLE.
REQ-021 In DONE, ACK=1 with START=1 SHALL transition directly to LOAD (back-to-back operation, no IDLE cycle).
REQ-022 In DONE, START=1 with ACK=0 SHALL be ignored.
REQ-023 START SHALL be ignored in LOAD and SHIFT; requests are not queued.
REQ-024 ABORT=1 in LOAD or SHIFT SHALL transition to IDLE on the next edge, clear CNT, and never assert DONE.
REQ-025 ABORT SHALL have priority over every other input.
REQ-026 ABORT=1 in IDLE or DONE SHALL transition to IDLE.
REQ-027 Latency: START sampled at edge k SHALL give LE in cycle k+1, SHE in cycles k+2..k+WIDTH+1, and DONE from cycle k+WIDTH+2.
REQ-028 LE and SHE SHALL never be high in the same cycle.
REQ-029 PoutE SHALL never be high while SHE=1.

Reset
REQ-030 RST_N=0 at a rising edge SHALL force IDLE and CNT=0, giving LE=SHE=CC=PoutE=BUSY=DONE=0 in the following cycle.
REQ-031 Reset SHALL override START, ACK and ABORT, including when asserted mid-SHIFT or in DONE.
REQ-032 No output SHALL change asynchronously with RST_N.
REQ-033 The first START after RST_N deasserts SHALL be honoured normally.

Structure
REQ-034 The state encoding constants (IDLE, LOAD, SHIFT, DONE) and the default WIDTH SHALL reside in the shared capstone package/include, for reuse by the top level and the bench.
REQ-035 The bit counter SHALL be one sub-module, bit_counter (clear, enable, terminal-count output), instantiated once; the FSM and output decode SHALL remain in serial_add_ctrl.

Verification
REQ-036 The bench SHALL cover a basic run: RST_N=0 for 2 cycles, then a START pulse -> LE=1 for 1 cycle, SHE=1 for exactly 8 cycles with CNT 0..7, then DONE=PoutE=1 holding until ACK, then IDLE.
REQ-037 The bench SHALL cover back-to-back operation: START=ACK=1 in DONE -> LOAD on the next cycle, and a second run of 8 SHE cycles.
REQ-038 The bench SHALL cover abort: ABORT=1 at CNT=4 -> IDLE on the next cycle, CNT=0, DONE never asserted.
REQ-039 The bench SHALL cover START=1 held continuously through LOAD and SHIFT -> exactly 8 SHE cycles, then DONE, with no restart until ACK.
REQ-040 The bench SHALL cover reset mid-SHIFT: RST_N=0 at CNT=5 -> all outputs 0 in the next cycle, and a subsequent START runs a full operation.
REQ-041 The bench SHALL cover datapath integration: the accumulator is loaded with 8'b10100100, the addend with 8'b00000011 -> Pout=8'b10100111 while DONE=1.
